rec_play_ctrl: RTL and testbench

- Sequencing controller for the recorder front panel.
- Turns debounced key pulses into a record/play/pause/stop state machine.
- Generates a one-second tick, tracks elapsed time and recorded length, and manages playback rate (1..8, fast or slow).
- Its outputs outTime/outRate drive the seven-segment display block directly; outRecEn/outPlayEn drive the audio datapath.

---
 rtl/rec_play_ctrl_pkg.sv | 35 +++
 rtl/rec_play_ctrl_if.sv | 31 +++
 rtl/rec_play_ctrl_sec_tick.sv | 27 ++
 rtl/rec_play_ctrl.sv | 170 +++++++++++++++++
 tb/tb_rec_play_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rec_play_ctrl_pkg.sv
// Shared definitions for the recorder front-panel sequencer: state encoding,
// key decode and rate floor.
package rec_play_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REC   = 3'd1,
        PLAY  = 3'd2,
        PREC  = 3'd3,
        PPLAY = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        KEY_NONE  = 3'd0,
        KEY_STOP  = 3'd1,
        KEY_PAUSE = 3'd2,
        KEY_PLAY  = 3'd3,
        KEY_REC   = 3'd4
    } key_t;

    localparam logic [3:0] RATE_MIN = 4'd1;

    // Only the highest-priority transport key of a cycle survives.
    function automatic key_t top_key(input logic stop, input logic pause,
                                     input logic play, input logic rec);
        key_t k;
        k = KEY_NONE;
        if (stop)       k = KEY_STOP;
        else if (pause) k = KEY_PAUSE;
        else if (play)  k = KEY_PLAY;
        else if (rec)   k = KEY_REC;
        return k;
    endfunction

endpackage

// File: rtl/rec_play_ctrl_if.sv
// Front-panel bundle between the key/display side (master) and the
// sequencer (slave).
interface rec_play_ctrl_if;
    // Keys are one-cycle pulses taken on the next rising edge with no
    // back-pressure; swSlow is a level; every output is a register.
    logic       keyRec;
    logic       keyPlay;
    logic       keyPause;
    logic       keyStop;
    logic       keyUp;
    logic       keyDown;
    logic       swSlow;
    logic [5:0] outTime;
    logic [3:0] outRate;
    logic [2:0] outState;
    logic       outRecEn;
    logic       outPlayEn;
    logic [5:0] outLen;
    logic       outDone;

    modport master (
        output keyRec, keyPlay, keyPause, keyStop, keyUp, keyDown, swSlow,
        input  outTime, outRate, outState, outRecEn, outPlayEn, outLen, outDone
    );

    modport slave (
        input  keyRec, keyPlay, keyPause, keyStop, keyUp, keyDown, swSlow,
        output outTime, outRate, outState, outRecEn, outPlayEn, outLen, outDone
    );

endinterface

// File: rtl/rec_play_ctrl_sec_tick.sv
// Seconds prescaler: counts 0..CLK_HZ-1 while run is high, holds otherwise,
// and flags the last count of each second.
module rec_play_ctrl_sec_tick #(
    parameter int CLK_HZ = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tick
);
    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/rec_play_ctrl.sv
// Record/play/pause/stop sequencer with elapsed-time, recorded-length and
// playback-rate registers feeding the display and audio datapath.
module rec_play_ctrl
    import rec_play_ctrl_pkg::*;
#(
    parameter int CLK_HZ   = 50000000,
    parameter int MAX_SEC  = 32,
    parameter int RATE_MAX = 8
) (
    input logic            clk,
    input logic            rst,
    rec_play_ctrl_if.slave bus
);
    localparam logic [5:0] MAX_T    = 6'(MAX_SEC);
    localparam logic [3:0] RATE_TOP = 4'(RATE_MAX);

    state_t     state_q, state_d;
    logic [5:0] time_q, time_d;
    logic [5:0] len_q, len_d;
    logic [3:0] rate_q, rate_d;
    logic [3:0] sub_q, sub_d;
    logic       slow_q;
    logic       done_q, done_d;
    logic       rec_en_q, play_en_q;
    logic       run, clr, tick, ended;
    logic [6:0] step, adv;
    key_t       key;

    assign run = (state_q == REC) || (state_q == PLAY);

    rec_play_ctrl_sec_tick #(.CLK_HZ(CLK_HZ)) u_sec_tick (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        len_d   = len_q;
        rate_d  = rate_q;
        sub_d   = sub_q;
        done_d  = 1'b0;
        ended   = 1'b0;
        clr     = 1'b0;
        step    = 7'd0;
        adv     = {1'b0, time_q};
        key     = top_key(bus.keyStop, bus.keyPause, bus.keyPlay, bus.keyRec);

        // The second's time update is applied first; keys then act on it.
        if (tick && state_q == REC) begin
            if ({1'b0, time_q} + 7'd1 == {1'b0, MAX_T}) begin
                time_d  = MAX_T;
                len_d   = MAX_T;
                state_d = IDLE;
                done_d  = 1'b1;
                ended   = 1'b1;
            end else begin
                time_d = time_q + 6'd1;
            end
        end else if (tick && state_q == PLAY) begin
            if (!bus.swSlow) begin
                step = {3'b000, rate_q};
            end else if (sub_q == rate_q - 4'd1) begin
                step  = 7'd1;
                sub_d = 4'd0;
            end else begin
                sub_d = sub_q + 4'd1;
            end
            adv = {1'b0, time_q} + step;
            if (adv >= {1'b0, len_q}) begin
                time_d  = len_q;
                state_d = IDLE;
                done_d  = 1'b1;
                ended   = 1'b1;
            end else begin
                time_d = adv[5:0];
            end
        end

        if (!ended) begin
            case (state_q)
                IDLE: begin
                    if (key == KEY_REC) begin
                        state_d = REC;
                        time_d  = 6'd0;
                        len_d   = 6'd0;
                        clr     = 1'b1;
                    end else if (key == KEY_PLAY && len_q != 6'd0) begin
                        state_d = PLAY;
                        time_d  = 6'd0;
                        sub_d   = 4'd0;
                        clr     = 1'b1;
                    end
                end
                REC: begin
                    if (key == KEY_STOP) begin
                        state_d = IDLE;
                        len_d   = time_d;
                    end else if (key == KEY_PAUSE) begin
                        state_d = PREC;
                    end
                end
                PREC: begin
                    if (key == KEY_STOP) begin
                        state_d = IDLE;
                        len_d   = time_q;
                    end else if (key == KEY_PLAY || key == KEY_REC) begin
                        state_d = REC;
                    end
                end
                PLAY: begin
                    if (key == KEY_STOP)       state_d = IDLE;
                    else if (key == KEY_PAUSE) state_d = PPLAY;
                end
                PPLAY: begin
                    if (key == KEY_STOP)      state_d = IDLE;
                    else if (key == KEY_PLAY) state_d = PLAY;
                end
                default: state_d = IDLE;
            endcase
        end

        if (bus.keyUp && !bus.keyDown && rate_q < RATE_TOP) begin
            rate_d = rate_q + 4'd1;
        end else if (bus.keyDown && !bus.keyUp && rate_q > RATE_MIN) begin
            rate_d = rate_q - 4'd1;
        end

        // A new rate or speed mode restarts the slow-play tick count.
        if (rate_d != rate_q || bus.swSlow != slow_q) begin
            sub_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            time_q    <= 6'd0;
            len_q     <= 6'd0;
            rate_q    <= RATE_MIN;
            sub_q     <= 4'd0;
            slow_q    <= 1'b0;
            done_q    <= 1'b0;
            rec_en_q  <= 1'b0;
            play_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            len_q     <= len_d;
            rate_q    <= rate_d;
            sub_q     <= sub_d;
            slow_q    <= bus.swSlow;
            done_q    <= done_d;
            rec_en_q  <= (state_d == REC);
            play_en_q <= (state_d == PLAY);
        end
    end

    assign bus.outState  = state_q;
    assign bus.outTime   = time_q;
    assign bus.outLen    = len_q;
    assign bus.outRate   = rate_q;
    assign bus.outDone   = done_q;
    assign bus.outRecEn  = rec_en_q;
    assign bus.outPlayEn = play_en_q;

endmodule

// File: tb/tb_rec_play_ctrl.sv
// Bench for rec_play_ctrl: directed vector table, corner sequences and a
// random run checked against an integer model of the panel behaviour.
module tb_rec_play_ctrl;

    localparam int CLK_HZ   = 4;
    localparam int MAX_SEC  = 10;
    localparam int RATE_MAX = 8;

    localparam int S_IDLE = 0, S_REC = 1, S_PLAY = 2, S_PREC = 3, S_PPLAY = 4;
    localparam int T_NONE = 0, T_STOP = 1, T_PAUSE = 2, T_PLAY = 3, T_REC = 4;

    // key vector bits: {rec, play, pause, stop, up, down}
    localparam logic [5:0] K_NONE  = 6'b000000;
    localparam logic [5:0] K_REC   = 6'b100000;
    localparam logic [5:0] K_PLAY  = 6'b010000;
    localparam logic [5:0] K_PAUSE = 6'b001000;
    localparam logic [5:0] K_STOP  = 6'b000100;
    localparam logic [5:0] K_UP    = 6'b000010;
    localparam logic [5:0] K_DOWN  = 6'b000001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    rec_play_ctrl_if bus ();

    rec_play_ctrl #(.CLK_HZ(CLK_HZ), .MAX_SEC(MAX_SEC), .RATE_MAX(RATE_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_cyc  = 0;
    logic [21:0] exp_q[$];

    // reference model state
    int m_state, m_time, m_len, m_rate, m_phase, m_slow_cnt, m_prev_slow;
    bit m_done;

    function automatic logic [21:0] pack(input int st, input int tm, input int rt,
                                         input int ln, input bit dn);
        return {3'(st), 6'(tm), 4'(rt), 6'(ln), (st == S_REC), (st == S_PLAY), dn};
    endfunction

    task automatic check_val(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic [5:0] k, input logic s);
        int ns, nt, nl, nc, np, nr, cand, ticks, top;
        bit tick, ended, dn;
        if (r) begin
            m_state = S_IDLE; m_time = 0; m_len = 0; m_rate = 1;
            m_phase = 0; m_slow_cnt = 0; m_prev_slow = 0; m_done = 0;
            return;
        end
        ns = m_state; nt = m_time; nl = m_len; nc = m_slow_cnt; np = m_phase;
        dn = 0; ended = 0; tick = 0; cand = 0; ticks = 0;
        if (m_state == S_REC || m_state == S_PLAY) begin
            if (m_phase == CLK_HZ - 1) begin
                tick = 1;
                np = 0;
            end else begin
                np = m_phase + 1;
            end
        end
        if (tick && m_state == S_REC) begin
            if (m_time + 1 == MAX_SEC) begin
                nt = MAX_SEC; nl = MAX_SEC; ns = S_IDLE; dn = 1; ended = 1;
            end else begin
                nt = m_time + 1;
            end
        end else if (tick && m_state == S_PLAY) begin
            if (!s) begin
                cand = m_time + m_rate;
            end else begin
                ticks = m_slow_cnt + 1;
                if (ticks == m_rate) begin
                    cand = m_time + 1;
                    nc = 0;
                end else begin
                    cand = m_time;
                    nc = ticks;
                end
            end
            if (cand >= m_len) begin
                nt = m_len; ns = S_IDLE; dn = 1; ended = 1;
            end else begin
                nt = cand;
            end
        end
        if (!ended) begin
            if (k[2])      top = T_STOP;
            else if (k[3]) top = T_PAUSE;
            else if (k[4]) top = T_PLAY;
            else if (k[5]) top = T_REC;
            else           top = T_NONE;
            case (m_state)
                S_IDLE: begin
                    if (top == T_REC) begin
                        ns = S_REC; nt = 0; nl = 0; np = 0;
                    end else if (top == T_PLAY && m_len != 0) begin
                        ns = S_PLAY; nt = 0; np = 0; nc = 0;
                    end
                end
                S_REC: begin
                    if (top == T_STOP) begin
                        ns = S_IDLE; nl = nt;
                    end else if (top == T_PAUSE) begin
                        ns = S_PREC;
                    end
                end
                S_PREC: begin
                    if (top == T_STOP) begin
                        ns = S_IDLE; nl = nt;
                    end else if (top == T_PLAY || top == T_REC) begin
                        ns = S_REC;
                    end
                end
                S_PLAY: begin
                    if (top == T_STOP)       ns = S_IDLE;
                    else if (top == T_PAUSE) ns = S_PPLAY;
                end
                S_PPLAY: begin
                    if (top == T_STOP)      ns = S_IDLE;
                    else if (top == T_PLAY) ns = S_PLAY;
                end
                default: ns = S_IDLE;
            endcase
        end
        nr = m_rate;
        if (k[1] && !k[0] && m_rate < RATE_MAX)  nr = m_rate + 1;
        else if (k[0] && !k[1] && m_rate > 1)    nr = m_rate - 1;
        if (nr != m_rate || int'(s) != m_prev_slow) nc = 0;
        m_state = ns; m_time = nt; m_len = nl; m_rate = nr;
        m_slow_cnt = nc; m_phase = np; m_done = dn; m_prev_slow = int'(s);
    endtask

    task automatic sb_check();
        logic [21:0] exp, act;
        exp = exp_q.pop_front();
        act = {bus.outState, bus.outTime, bus.outRate, bus.outLen,
               bus.outRecEn, bus.outPlayEn, bus.outDone};
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL sb cycle %0d: got %h expected %h", n_cyc, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge.
    task automatic step(input logic r, input logic [5:0] k, input logic s);
        rst          = r;
        bus.keyRec   = k[5];
        bus.keyPlay  = k[4];
        bus.keyPause = k[3];
        bus.keyStop  = k[2];
        bus.keyUp    = k[1];
        bus.keyDown  = k[0];
        bus.swSlow   = s;
        model_step(r, k, s);
        exp_q.push_back(pack(m_state, m_time, m_rate, m_len, m_done));
        @(posedge clk);
        #1;
        n_cyc++;
        sb_check();
    endtask

    task automatic check_all(input string tag, input int st, input int tm,
                             input int rt, input int ln, input int dn);
        check_val({tag, ".state"},  int'(bus.outState),  st);
        check_val({tag, ".time"},   int'(bus.outTime),   tm);
        check_val({tag, ".rate"},   int'(bus.outRate),   rt);
        check_val({tag, ".len"},    int'(bus.outLen),    ln);
        check_val({tag, ".done"},   int'(bus.outDone),   dn);
        check_val({tag, ".recen"},  int'(bus.outRecEn),  int'(st == S_REC));
        check_val({tag, ".playen"}, int'(bus.outPlayEn), int'(st == S_PLAY));
    endtask

    typedef struct {
        logic       rst;
        logic [5:0] keys;
        logic       slow;
        int         ncyc;
        int         e_state, e_time, e_rate, e_len, e_done;
    } vec_t;

    vec_t vecs[31];

    initial begin
        logic [5:0] k;
        logic       r, cur_slow;

        bus.keyRec = 0; bus.keyPlay = 0; bus.keyPause = 0; bus.keyStop = 0;
        bus.keyUp = 0; bus.keyDown = 0; bus.swSlow = 0;

        // keys pulse on the first cycle of a row; the row then idles for ncyc-1
        vecs[0]  = '{1, K_NONE,  0,  1, S_IDLE,  0, 1,  0, 0};
        vecs[1]  = '{1, K_NONE,  0,  1, S_IDLE,  0, 1,  0, 0};
        vecs[2]  = '{0, K_PLAY,  0,  1, S_IDLE,  0, 1,  0, 0};
        vecs[3]  = '{0, K_REC,   0,  1, S_REC,   0, 1,  0, 0};
        vecs[4]  = '{0, K_NONE,  0, 20, S_REC,   5, 1,  0, 0};
        vecs[5]  = '{0, K_STOP,  0,  1, S_IDLE,  5, 1,  5, 0};
        vecs[6]  = '{0, K_REC,   0,  1, S_REC,   0, 1,  0, 0};
        vecs[7]  = '{0, K_NONE,  0, 40, S_IDLE, 10, 1, 10, 1};
        vecs[8]  = '{0, K_NONE,  0,  1, S_IDLE, 10, 1, 10, 0};
        vecs[9]  = '{0, K_UP,    0,  1, S_IDLE, 10, 2, 10, 0};
        vecs[10] = '{0, K_UP,    0,  1, S_IDLE, 10, 3, 10, 0};
        vecs[11] = '{0, K_UP,    0,  1, S_IDLE, 10, 4, 10, 0};
        vecs[12] = '{0, K_PLAY,  0,  1, S_PLAY,  0, 4, 10, 0};
        vecs[13] = '{0, K_NONE,  0,  4, S_PLAY,  4, 4, 10, 0};
        vecs[14] = '{0, K_NONE,  0,  4, S_PLAY,  8, 4, 10, 0};
        vecs[15] = '{0, K_NONE,  0,  4, S_IDLE, 10, 4, 10, 1};
        vecs[16] = '{0, K_NONE,  0,  1, S_IDLE, 10, 4, 10, 0};
        vecs[17] = '{0, K_REC,   0,  1, S_REC,   0, 4,  0, 0};
        vecs[18] = '{0, K_NONE,  0, 20, S_REC,   5, 4,  0, 0};
        vecs[19] = '{0, K_STOP,  0,  1, S_IDLE,  5, 4,  5, 0};
        vecs[20] = '{0, K_DOWN,  0,  1, S_IDLE,  5, 3,  5, 0};
        vecs[21] = '{0, K_DOWN,  0,  1, S_IDLE,  5, 2,  5, 0};
        vecs[22] = '{0, K_NONE,  1,  1, S_IDLE,  5, 2,  5, 0};
        vecs[23] = '{0, K_PLAY,  1,  1, S_PLAY,  0, 2,  5, 0};
        vecs[24] = '{0, K_NONE,  1,  8, S_PLAY,  1, 2,  5, 0};
        vecs[25] = '{0, K_NONE,  1,  6, S_PLAY,  1, 2,  5, 0};
        vecs[26] = '{0, K_PAUSE, 1,  1, S_PPLAY, 1, 2,  5, 0};
        vecs[27] = '{0, K_NONE,  1, 10, S_PPLAY, 1, 2,  5, 0};
        vecs[28] = '{0, K_PLAY,  1,  1, S_PLAY,  1, 2,  5, 0};
        vecs[29] = '{0, K_NONE,  1,  1, S_PLAY,  2, 2,  5, 0};
        vecs[30] = '{0, K_STOP | K_PAUSE, 1, 1, S_IDLE, 2, 2, 5, 0};

        for (int i = 0; i < 31; i++) begin
            step(vecs[i].rst, vecs[i].keys, vecs[i].slow);
            for (int c = 1; c < vecs[i].ncyc; c++) step(1'b0, K_NONE, vecs[i].slow);
            check_all($sformatf("row%0d", i), vecs[i].e_state, vecs[i].e_time,
                      vecs[i].e_rate, vecs[i].e_len, vecs[i].e_done);
        end

        // rate saturation at the top and simultaneous up/down
        for (int i = 0; i < 10; i++) step(1'b0, K_UP, 1'b1);
        check_val("rate_sat_hi", int'(bus.outRate), RATE_MAX);
        step(1'b0, K_UP | K_DOWN, 1'b1);
        check_val("rate_updown", int'(bus.outRate), RATE_MAX);

        // reset in the middle of playback discards everything
        step(1'b0, K_PLAY, 1'b0);
        check_val("midplay.state", int'(bus.outState), S_PLAY);
        for (int i = 0; i < 5; i++) step(1'b0, K_NONE, 1'b0);
        step(1'b1, K_NONE, 1'b0);
        check_all("midrst", S_IDLE, 0, 1, 0, 0);
        step(1'b0, K_PLAY, 1'b0);
        check_val("play_after_rst.state", int'(bus.outState), S_IDLE);
        step(1'b0, K_DOWN, 1'b0);
        check_val("rate_sat_lo", int'(bus.outRate), 1);

        // random traffic against the model
        cur_slow = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            k[5] = ($urandom_range(0, 11) == 0);
            k[4] = ($urandom_range(0, 11) == 0);
            k[3] = ($urandom_range(0, 15) == 0);
            k[2] = ($urandom_range(0, 39) == 0);
            k[1] = ($urandom_range(0, 19) == 0);
            k[0] = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0) cur_slow = ~cur_slow;
            r = ($urandom_range(0, 999) == 0);
            step(r, k, cur_slow);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
